fpu_issue: RTL and testbench

- Dispatch stage that sits directly upstream of the FPU wrapper.
- Accepts one float op per handshake from decode and drives the FPU's `ctl`/`x1`/`x2`/`en` interface.
- Holds operands and `ctl` stable until the FPU's one-cycle `ready` pulse, captures the result and presents it to writeback with a valid/ready handshake.
- Single outstanding op. Also filters unsupported opcodes and guards against a hung FPU with a timeout.

---
 rtl/fpu_issue_if.sv | 43 ++++
 rtl/fpu_issue.sv | 116 +++++++++++
 tb/tb_fpu_issue.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_if.sv
// Decode-request, FPU-drive and writeback bundle for the fpu_issue dispatch stage.
// slave is the dispatch stage's view; master is the surrounding environment's view.
interface fpu_issue_if #(
  parameter int RD_W = 5
);
  logic            req_valid;
  logic            req_ready;
  logic [3:0]      req_op;
  logic [31:0]     req_x1;
  logic [31:0]     req_x2;
  logic [RD_W-1:0] req_rd;

  logic [3:0]      fpu_ctl;
  logic [31:0]     fpu_x1;
  logic [31:0]     fpu_x2;
  logic            fpu_en;
  logic            fpu_ready;
  logic [31:0]     fpu_y;

  logic            wb_valid;
  logic            wb_ready;
  logic [31:0]     wb_data;
  logic [RD_W-1:0] wb_rd;
  logic            wb_is_int;

  modport slave (
    input  req_valid, req_op, req_x1, req_x2, req_rd,
    output req_ready,
    output fpu_ctl, fpu_x1, fpu_x2, fpu_en,
    input  fpu_ready, fpu_y,
    output wb_valid, wb_data, wb_rd, wb_is_int,
    input  wb_ready
  );

  modport master (
    output req_valid, req_op, req_x1, req_x2, req_rd,
    input  req_ready,
    input  fpu_ctl, fpu_x1, fpu_x2, fpu_en,
    output fpu_ready, fpu_y,
    input  wb_valid, wb_data, wb_rd, wb_is_int,
    output wb_ready
  );
endinterface

// File: rtl/fpu_issue.sv
// Single-outstanding dispatch stage in front of the FPU wrapper: issues one op,
// waits for the completion pulse (with timeout), and hands the result to writeback.
module fpu_issue #(
  parameter int TIMEOUT = 32,
  parameter int RD_W    = 5
) (
  input  logic          clk,
  input  logic          rstn,
  fpu_issue_if.slave    io,
  output logic          busy,
  output logic          err_illegal,
  output logic          err_timeout
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state, state_nx;
  logic [3:0]      ctl_q;
  logic [31:0]     x1_q;
  logic [31:0]     x2_q;
  logic [31:0]     data_q;
  logic [RD_W-1:0] rd_q;
  logic            is_int_q;
  logic [CNT_W-1:0] cnt_q;

  logic req_ready;
  logic accept;
  logic op_legal;
  logic capture;
  logic expire;

  function automatic logic is_legal(input logic [3:0] op);
    return !(op inside {4'd6, 4'd7, 4'd8, 4'd13, 4'd14, 4'd15});
  endfunction

  // NOTE: every signal driven here gets a default before the case, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    req_ready = (state == IDLE) || (state == DONE && io.wb_ready);
    accept    = io.req_valid && req_ready;
    op_legal  = is_legal(io.req_op);
    capture   = (state == WAIT) && io.fpu_ready;
    // A completion pulse on the expiry cycle takes priority over the timeout.
    expire    = (state == WAIT) && !io.fpu_ready && (cnt_q == CNT_W'(TIMEOUT - 1));
    state_nx  = state;
    unique case (state)
      IDLE:    if (accept) state_nx = op_legal ? ISSUE : DONE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (capture || expire) state_nx = DONE;
      DONE: begin
        if (accept)           state_nx = op_legal ? ISSUE : DONE;
        else if (io.wb_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: the operand/result registers are reset as well, because fpu_ctl/x1/x2
  // and the writeback fields are architecturally visible and must read zero after reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ctl_q       <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      rd_q        <= '0;
      is_int_q    <= 1'b0;
      data_q      <= '0;
      cnt_q       <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      // Operands only move on accept: the FPU picks its result by ctl at completion.
      if (accept) begin
        ctl_q    <= io.req_op;
        x1_q     <= io.req_x1;
        x2_q     <= io.req_x2;
        rd_q     <= io.req_rd;
        is_int_q <= (io.req_op == 4'd9) || (io.req_op == 4'd10);
        if (!op_legal) begin
          data_q      <= '0;
          err_illegal <= 1'b1;
        end
      end

      if (state == ISSUE)                     cnt_q <= '0;
      else if (state == WAIT && !io.fpu_ready) cnt_q <= cnt_q + 1'b1;

      if (capture) data_q <= io.fpu_y;
      if (expire) begin
        data_q      <= '0;
        err_timeout <= 1'b1;
      end
    end
  end

  assign io.req_ready = req_ready;
  assign io.fpu_ctl   = ctl_q;
  assign io.fpu_x1    = x1_q;
  assign io.fpu_x2    = x2_q;
  assign io.fpu_en    = (state == ISSUE);
  assign io.wb_valid  = (state == DONE);
  assign io.wb_data   = data_q;
  assign io.wb_rd     = rd_q;
  assign io.wb_is_int = is_int_q;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_fpu_issue.sv
// Self-checking bench for fpu_issue: stub FPU with programmable latency and a
// writeback scoreboard fed at accept time, plus cycle-exact timing checks.
module tb_fpu_issue;
  localparam int RD_W    = 5;
  localparam int TIMEOUT = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic busy, err_illegal, err_timeout;

  fpu_issue_if #(.RD_W(RD_W)) bus ();

  fpu_issue #(.TIMEOUT(TIMEOUT), .RD_W(RD_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .io          (bus.slave),
    .busy        (busy),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0]     data;
    logic [RD_W-1:0] rd;
    logic            is_int;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks    = 0;
  int n_pass      = 0;
  int cyc         = 0;
  int last_wb_cyc = -1;

  int          stub_k = 0;
  logic [31:0] stub_y = '0;
  int          pend   = 0;
  logic [31:0] pend_y = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Stub FPU: an fpu_en seen in cycle E raises fpu_ready in cycle E+k (k=0 never answers).
  initial begin
    bus.fpu_ready = 1'b0;
    bus.fpu_y     = '0;
    forever begin
      @(negedge clk);
      if (bus.fpu_en && stub_k > 0) begin
        pend   = stub_k;
        pend_y = stub_y;
      end
      @(posedge clk);
      #1;
      bus.fpu_ready = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.fpu_ready = 1'b1;
          bus.fpu_y     = pend_y;
        end
      end
    end
  end

  // Writeback monitor: every completed handshake is compared against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (bus.wb_valid && bus.wb_ready) begin
      if (exp_q.size() == 0) begin
        check("wb_spurious", 32'(bus.wb_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_data", bus.wb_data, mon_e.data);
        check("wb_rd", 32'(bus.wb_rd), 32'(mon_e.rd));
        check("wb_is_int", 32'(bus.wb_is_int), 32'(mon_e.is_int));
        last_wb_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at a drive point; returns at the drive point of the cycle after accept.
  task automatic send(input logic [3:0] op, input logic [31:0] x1, input logic [31:0] x2,
                      input logic [RD_W-1:0] rd, input logic [31:0] y, input int k,
                      input logic [31:0] exp_data, output int t);
    bit got = 1'b0;
    stub_k        = k;
    stub_y        = y;
    bus.req_op    = op;
    bus.req_x1    = x1;
    bus.req_x2    = x2;
    bus.req_rd    = rd;
    bus.req_valid = 1'b1;
    t = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        got = 1'b1;
        t   = cyc;
      end else begin
        step();
      end
    end
    check("accept", 32'(bus.req_ready), 32'd1);
    exp_q.push_back('{data: exp_data, rd: rd, is_int: (op == 4'd9 || op == 4'd10)});
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    step();
  endtask

  initial begin
    int t, t2, viol;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_x1    = '0;
    bus.req_x2    = '0;
    bus.req_rd    = '0;
    bus.wb_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_fpu_en", 32'(bus.fpu_en), 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_err", {30'd0, err_illegal, err_timeout}, 32'd0);
    check("rst_fpu_ctl", 32'(bus.fpu_ctl), 32'd0);
    step();

    // fhalf with a one-cycle FPU
    bus.wb_ready = 1'b1;
    send(4'd5, 32'h4080_0000, 32'h0, 5'd1, 32'h4000_0000, 1, 32'h4000_0000, t);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("t1_fpu_en", 32'(bus.fpu_en), 32'(c == 1));
      check("t1_busy", 32'(busy), 32'(c <= 3));
      check("t1_wb_valid", 32'(bus.wb_valid), 32'(c == 3));
      step();
    end
    check("t1_wb_latency", 32'(last_wb_cyc - t), 32'd3);

    // fdiv with k=10, then a back-to-back fmul accepted in the result cycle
    send(4'd4, 32'h4120_0000, 32'h4040_0000, 5'd2, 32'h4055_5555, 10, 32'h4055_5555, t);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      check("t2_fpu_ctl", 32'(bus.fpu_ctl), 32'd4);
      check("t2_fpu_x1", bus.fpu_x1, 32'h4120_0000);
      check("t2_fpu_x2", bus.fpu_x2, 32'h4040_0000);
      step();
    end
    send(4'd2, 32'h3fc0_0000, 32'h4000_0000, 5'd3, 32'h4040_0000, 1, 32'h4040_0000, t2);
    check("t2_wb_latency", 32'(last_wb_cyc - t), 32'd12);
    check("t2_b2b_accept", 32'(t2 - t), 32'd12);
    @(negedge clk);
    check("t2_b2b_fpu_en", 32'(bus.fpu_en), 32'd1);
    check("t2_b2b_fpu_ctl", 32'(bus.fpu_ctl), 32'd2);
    check("t2_b2b_fpu_x1", bus.fpu_x1, 32'h3fc0_0000);
    step();
    wait_idle("t2");
    check("t2_b2b_latency", 32'(last_wb_cyc - t2), 32'd3);

    // feq with writeback stalled for five cycles
    bus.wb_ready = 1'b0;
    send(4'd9, 32'h3f80_0000, 32'h3f80_0000, 5'd7, 32'd1, 1, 32'd1, t);
    repeat (2) begin
      @(negedge clk);
      step();
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t3_wb_valid", 32'(bus.wb_valid), 32'd1);
      check("t3_wb_data", bus.wb_data, 32'd1);
      check("t3_wb_is_int", 32'(bus.wb_is_int), 32'd1);
      check("t3_wb_rd", 32'(bus.wb_rd), 32'd7);
      check("t3_req_ready", 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.wb_ready = 1'b1;
    @(negedge clk);
    check("t3_req_ready_rel", 32'(bus.req_ready), 32'd1);
    step();
    wait_idle("t3");
    check("t3_wb_cycle", 32'(last_wb_cyc - t), 32'd8);

    // illegal opcode, then a legal fabs
    send(4'd7, 32'h1234_5678, 32'h9abc_def0, 5'd4, 32'hdead_beef, 1, 32'd0, t);
    @(negedge clk);
    check("t4_fpu_en", 32'(bus.fpu_en), 32'd0);
    check("t4_wb_valid", 32'(bus.wb_valid), 32'd1);
    check("t4_err_illegal", 32'(err_illegal), 32'd1);
    step();
    wait_idle("t4a");
    send(4'd11, 32'hc000_0000, 32'h0, 5'd9, 32'h4000_0000, 3, 32'h4000_0000, t);
    wait_idle("t4b");
    check("t4_legal_latency", 32'(last_wb_cyc - t), 32'd5);
    check("t4_err_illegal_sticky", 32'(err_illegal), 32'd1);
    check("t4_err_timeout", 32'(err_timeout), 32'd0);

    // completion exactly on the expiry cycle
    send(4'd0, 32'h3f80_0000, 32'h3f80_0000, 5'd10, 32'h4000_0000, TIMEOUT, 32'h4000_0000, t);
    wait_idle("t5a");
    check("t5_expiry_latency", 32'(last_wb_cyc - t), 32'(TIMEOUT + 2));
    check("t5_expiry_no_err", 32'(err_timeout), 32'd0);

    // FPU never answers
    send(4'd1, 32'h3f80_0000, 32'h3f80_0000, 5'd11, 32'h1111_1111, 0, 32'd0, t);
    wait_idle("t5b");
    check("t5_timeout_latency", 32'(last_wb_cyc - t), 32'(TIMEOUT + 2));
    check("t5_err_timeout", 32'(err_timeout), 32'd1);

    // reset in the middle of an fmul WAIT; the late completion pulse must be ignored
    send(4'd2, 32'h4040_0000, 32'h4080_0000, 5'd12, 32'h4140_0000, 20, 32'h4140_0000, t);
    repeat (3) begin
      @(negedge clk);
      step();
    end
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_req_ready", 32'(bus.req_ready), 32'd1);
    check("t6_fpu_en", 32'(bus.fpu_en), 32'd0);
    check("t6_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("t6_fpu_ctl", 32'(bus.fpu_ctl), 32'd0);
    check("t6_fpu_x1", bus.fpu_x1, 32'd0);
    check("t6_fpu_x2", bus.fpu_x2, 32'd0);
    check("t6_wb_data", bus.wb_data, 32'd0);
    check("t6_wb_rd", 32'(bus.wb_rd), 32'd0);
    check("t6_wb_is_int", 32'(bus.wb_is_int), 32'd0);
    check("t6_errs", {30'd0, err_illegal, err_timeout}, 32'd0);
    step();
    viol = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (busy || bus.wb_valid) viol++;
      step();
    end
    check("t6_late_ready_ignored", 32'(viol), 32'd0);

    // normal operation resumes after reset
    send(4'd12, 32'h3f80_0000, 32'h0, 5'd13, 32'hbf80_0000, 1, 32'hbf80_0000, t);
    wait_idle("t6");
    check("t6_resume_latency", 32'(last_wb_cyc - t), 32'd3);
    check("t6_resume_errs", {30'd0, err_illegal, err_timeout}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
